step_pulse_gen: RTL
===================

Name: step_pulse_gen

Overview:
- Downstream of the tracking-mode controller.
- Consumes its step period, direction and drive-enable outputs; produces the physical STEP/DIR signals for the stepper driver.
- Enforces driver timing: step pulse width, DIR setup before a step, and a minimum step period.
- Keeps a signed running step position for readback.

Parameters:
- WIDTH_WORK, 16, width of period_in (step period in ticks)
- PRESCALE, 50, clk cycles per tick (1 us at 50 MHz)
- PULSE_W, 5, STEP high width in ticks
- DIR_SETUP, 5, ticks dir_out must be stable before a STEP rising edge
- MIN_PERIOD, 20, minimum step period in ticks; must be greater than PULSE_W
- POS_W, 32, position counter width

Ports:
- clk, input, 1, system clock, 50 MHz
- rst, input, 1, asynchronous active-high reset
- period_in, input, WIDTH_WORK, requested step period in ticks; 0 means stop
- dir_in, input, 1, requested direction (1 = forward)
- drv_en, input, 1, drive enable from the tracking controller
- step_out, output, 1, STEP to the driver
- dir_out, output, 1, DIR to the driver
- busy, output, 1, high when the state is not IDLE
- step_done, output, 1, one-clk pulse at the end of each full step period
- position, output, POS_W, signed step count

Behaviour:
- Reset values: step_out=0, dir_out=0, busy=0, step_done=0, position=0, state=IDLE, all counters=0.
- Tick generator:
  - pre_cnt counts 0..PRESCALE-1; tick=1 for one clk when pre_cnt==PRESCALE-1.
  - pre_cnt and tick_cnt clear on every state entry, so intervals are exact multiples of PRESCALE clks.
- Period latch: period_lat <= max(period_in, MIN_PERIOD), captured on each entry to PULSE_HIGH. A new period_in takes effect only at step boundaries.
- States:
  - IDLE: step_out=0.
    - If drv_en=1 and period_in!=0 and dir_in!=dir_out: dir_out<=dir_in, go to DIR_SETUP.
    - If drv_en=1 and period_in!=0 and dir_in==dir_out: go to PULSE_HIGH.
    - Latency from the sampling edge to step_out=1 is 1 clk.
  - DIR_SETUP:
    - If drv_en=0 or period_in==0: go to IDLE immediately.
    - Else after DIR_SETUP ticks (DIR_SETUP*PRESCALE clks): go to PULSE_HIGH.
  - PULSE_HIGH entry: step_out<=1, latch period, position += 1 if dir_out=1, else -= 1. Position wraps two's complement.
  - PULSE_HIGH: after PULSE_W ticks, step_out<=0 and go to PULSE_LOW. The high pulse is never truncated, even if drv_en drops.
  - PULSE_LOW:
    - If drv_en=0 or period_in==0, and at least PULSE_W ticks have elapsed: go to IDLE. No step_done is issued.
    - On reaching period_lat-PULSE_W ticks: step_done=1 for 1 clk, then:
      - disabled or period_in==0: go to IDLE
      - dir_in!=dir_out: dir_out<=dir_in, go to DIR_SETUP
      - otherwise: go to PULSE_HIGH (rising edges exactly period_lat*PRESCALE clks apart)
- dir_out changes only in IDLE or at the PULSE_LOW exit. It never changes while step_out=1 or within DIR_SETUP ticks before a rising edge.
- Direction reversal sequence: finish the current period, then DIR_SETUP, then step.
- Simultaneous drv_en rise and dir change in IDLE: DIR_SETUP takes priority, so there is no immediate step.
- rst mid-operation: all outputs return to reset values at once, and step_out drops asynchronously.

Decomposition:
- Shared package stepper_pkg holds:
  - state enum {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW}
  - WIDTH_WORK
  - default timing constants (PULSE_W, DIR_SETUP, MIN_PERIOD)
- One sub-module, step_tick_prescaler:
  - inputs: clk, rst, clr
  - output: tick
  - parameter: PRESCALE

Test Plan:
- Constant run: drv_en=1, dir_in=0 (matches dir_out reset), period_in=100 → first rise 1 clk later; rises every 5000 clks; high width 250 clks; position -1 per step; step_done once per step.
- Clamp: period_in=3 → period 20 ticks (1000 clks between rising edges).
- Reversal: running with dir_in=0 and period 100, then dir_in=1 → current period completes; dir_out toggles; next rise exactly 250 clks later; dir_out stable throughout every high pulse; position starts incrementing.
- Disable mid-pulse: drop drv_en 10 clks after a rise → step_out stays high the full 250 clks; IDLE reached after 250 more low clks; busy=0; no further rises.
- Period change: period_in 100→40 mid-step → current step keeps 5000 clks; next step is 2000 clks.
- Async reset: assert rst while step_out=1 → step_out, position, busy = 0 without waiting for a clk edge; normal operation resumes after release.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper drive slice.
// Contents:
//   step_state_e    - pulse generator state encoding
//   *_DEF           - default work width and driver timing constants (in ticks)
//   max_u           - unsigned maximum, used to clamp the step period
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIR_SETUP  = 2'd1,
    ST_PULSE_HIGH = 2'd2,
    ST_PULSE_LOW  = 2'd3
  } step_state_e;

  localparam int WIDTH_WORK_DEF = 16;
  localparam int PULSE_W_DEF    = 5;
  localparam int DIR_SETUP_DEF  = 5;
  localparam int MIN_PERIOD_DEF = 20;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/step_tick_prescaler.sv
// Divides clk down to a one-clk tick every PRESCALE clks.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clr      - restarts the division so the next tick lands exactly PRESCALE clks later
//   tick     - registered one-clk pulse
module step_tick_prescaler
  import stepper_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick_q, tick_d;

  // Next prescale count; tick is precomputed so it is high while the count sits at LAST.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = {CW{1'b0}};
    end else if (pre_cnt_q == LAST) begin
      pre_cnt_d = {CW{1'b0}};
    end else begin
      pre_cnt_d = pre_cnt_q + CW'(1);
    end
    tick_d = (pre_cnt_d == LAST);
  end

  // Prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= {CW{1'b0}};
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR generator for the stepper driver. Turns the tracking controller's
// period/direction/enable into driver pulses while enforcing pulse width,
// DIR setup before each rising edge and a minimum step period.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   period_in  - step period in ticks, 0 = stop
//   dir_in     - requested direction (1 = forward)
//   drv_en     - drive enable
//   step_out   - STEP to driver
//   dir_out    - DIR to driver
//   busy       - state is not IDLE
//   step_done  - one-clk pulse at the end of each full step period
//   position   - signed running step count (wraps)
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int WIDTH_WORK = WIDTH_WORK_DEF,
  parameter int PRESCALE   = 50,
  parameter int PULSE_W    = PULSE_W_DEF,
  parameter int DIR_SETUP  = DIR_SETUP_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int POS_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH_WORK-1:0]   period_in,
  input  logic                    dir_in,
  input  logic                    drv_en,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic                    step_done,
  output logic signed [POS_W-1:0] position
);

  localparam int TW = WIDTH_WORK + 1;
  localparam logic [TW-1:0] PULSE_T = TW'(PULSE_W);
  localparam logic [TW-1:0] SETUP_T = TW'(DIR_SETUP);

  step_state_e           state_q, state_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [WIDTH_WORK-1:0] period_lat_q, period_lat_d;
  logic [WIDTH_WORK-1:0] tick_cnt_q, tick_cnt_d;

  logic                  tick_s;
  logic                  clr_s;
  logic                  run_req_s;
  logic [TW-1:0]         ticks_done_s;
  logic [TW-1:0]         low_target_s;
  logic [WIDTH_WORK-1:0] period_clamp_s;

  step_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  assign run_req_s      = drv_en && (period_in != {WIDTH_WORK{1'b0}});
  // Ticks elapsed in the current state, counting a tick that lands this clk.
  assign ticks_done_s   = {1'b0, tick_cnt_q} + {{WIDTH_WORK{1'b0}}, tick_s};
  // Low phase length makes the rising-edge spacing exactly period_lat ticks.
  assign low_target_s   = {1'b0, period_lat_q} - PULSE_T;
  assign period_clamp_s = WIDTH_WORK'(max_u(32'(period_in), 32'(MIN_PERIOD)));

  // Next-state, entry actions and next output values.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    pos_d        = pos_q;
    period_lat_d = period_lat_q;

    case (state_q)
      ST_IDLE: begin
        if (run_req_s) begin
          // A pending direction change always goes through DIR_SETUP first.
          if (dir_in != dir_q) begin
            dir_d   = dir_in;
            state_d = ST_DIR_SETUP;
          end else begin
            state_d = ST_PULSE_HIGH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIR_SETUP: begin
        if (!run_req_s) begin
          state_d = ST_IDLE;
        end else if (tick_s && (ticks_done_s == SETUP_T)) begin
          state_d = ST_PULSE_HIGH;
        end else begin
          state_d = ST_DIR_SETUP;
        end
      end
      ST_PULSE_HIGH: begin
        // The high pulse always runs its full width, regardless of enable.
        if (tick_s && (ticks_done_s == PULSE_T)) begin
          state_d = ST_PULSE_LOW;
        end else begin
          state_d = ST_PULSE_HIGH;
        end
      end
      ST_PULSE_LOW: begin
        if (tick_s && (ticks_done_s == low_target_s)) begin
          done_d = 1'b1;
          if (!run_req_s) begin
            state_d = ST_IDLE;
          end else if (dir_in != dir_q) begin
            dir_d   = dir_in;
            state_d = ST_DIR_SETUP;
          end else begin
            state_d = ST_PULSE_HIGH;
          end
        end else if (!run_req_s && (ticks_done_s >= PULSE_T)) begin
          // Stopping early still honours a minimum low time of PULSE_W ticks.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PULSE_LOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_PULSE_HIGH) && (state_q != ST_PULSE_HIGH)) begin
      period_lat_d = period_clamp_s;
      if (dir_q) begin
        pos_d = pos_q + POS_W'(1);
      end else begin
        pos_d = pos_q - POS_W'(1);
      end
    end else begin
      period_lat_d = period_lat_q;
      pos_d        = pos_q;
    end

    step_d = (state_d == ST_PULSE_HIGH);
    busy_d = (state_d != ST_IDLE);

    // Interval timing restarts on every state entry and is held cleared in IDLE.
    clr_s = (state_d != state_q) || (state_q == ST_IDLE);
    if (clr_s) begin
      tick_cnt_d = {WIDTH_WORK{1'b0}};
    end else if (tick_s) begin
      tick_cnt_d = ticks_done_s[WIDTH_WORK-1:0];
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pos_q        <= {POS_W{1'b0}};
      period_lat_q <= {WIDTH_WORK{1'b0}};
      tick_cnt_q   <= {WIDTH_WORK{1'b0}};
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pos_q        <= pos_d;
      period_lat_q <= period_lat_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;
  assign step_done = done_q;
  assign position  = $signed(pos_q);

endmodule
